// File: rtl/rv_pkg.sv
// Shared RV32I fetch-side definitions: address width, reset vector, fetch FSM states.
package rv_pkg;
  localparam int              XLEN         = 32;
  localparam logic [31:0]     RESET_PC_DEF = 32'h0000_0000;
  localparam int              INSTR_BYTES  = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_e;
endpackage

// File: rtl/br_target_add.sv
// Redirect target selection: branch adder, JALR bit-0 clear, JALR priority, misalign check.
module br_target_add
  import rv_pkg::*;
(
  input  logic            br_take_i,
  input  logic [XLEN-1:0] br_pc_i,
  input  logic [XLEN-1:0] br_off_i,
  input  logic            jalr_i,
  input  logic [XLEN-1:0] jalr_target_i,
  output logic            redir_o,
  output logic [XLEN-1:0] tgt_o,
  output logic            mis_o
);
  logic [XLEN-1:0] bt;
  logic [XLEN-1:0] jt;

  // Offset arrives pre-shifted, so this is a plain wrapping add.
  assign bt      = br_pc_i + br_off_i;
  assign jt      = {jalr_target_i[XLEN-1:1], 1'b0};
  assign tgt_o   = jalr_i ? jt : bt;
  assign redir_o = jalr_i | br_take_i;
  // Bit 0 is clear for every legal source, so only bit 1 can break word alignment.
  assign mis_o   = redir_o & tgt_o[1];
endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: holds the fetch PC, offers it over valid/ready, applies
// branch/JALR redirects and buffers one redirect while fetch is stalled.
module pc_gen #(
  parameter logic [31:0] RESET_PC = rv_pkg::RESET_PC_DEF,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_take_i,
  input  logic [XLEN-1:0] br_pc_i,
  input  logic [XLEN-1:0] br_off_i,
  input  logic            jalr_i,
  input  logic [XLEN-1:0] jalr_target_i,
  input  logic            if_ready_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic            flush_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
);
  import rv_pkg::*;

  if (XLEN != 32) begin : g_xlen_chk
    $error("pc_gen supports XLEN=32 only");
  end

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic [XLEN-1:0] maddr_q, maddr_d;
  logic            flush_q, flush_d;
  logic            mis_q, mis_d;

  logic            redir;
  logic            tgt_mis;
  logic [XLEN-1:0] tgt;
  logic            xfer;

  br_target_add u_tgt (
    .br_take_i     (br_take_i),
    .br_pc_i       (br_pc_i),
    .br_off_i      (br_off_i),
    .jalr_i        (jalr_i),
    .jalr_target_i (jalr_target_i),
    .redir_o       (redir),
    .tgt_o         (tgt),
    .mis_o         (tgt_mis)
  );

  assign if_valid_o      = (state_q != BOOT);
  assign xfer            = if_valid_o & if_ready_i;
  assign if_pc_o         = pc_q;
  assign flush_o         = flush_q;
  assign misalign_o      = mis_q;
  assign misalign_addr_o = maddr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      maddr_q <= '0;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      maddr_q <= maddr_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    maddr_d = maddr_q;
    flush_d = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redir && tgt_mis) begin
          // Misaligned target: report it, squash, but keep fetching in order.
          flush_d = 1'b1;
          mis_d   = 1'b1;
          maddr_d = tgt;
          if (xfer) pc_d = pc_q + XLEN'(INSTR_BYTES);
        end else if (redir) begin
          flush_d = 1'b1;
          if (xfer) begin
            pc_d = tgt;
          end else begin
            // pc must stay stable while offered; park the target.
            pend_d  = tgt;
            state_d = PEND;
          end
        end else if (xfer) begin
          pc_d = pc_q + XLEN'(INSTR_BYTES);
        end
      end
      PEND: begin
        // The stale pc just accepted must be squashed as well.
        if (xfer) begin
          pc_d    = pend_q;
          flush_d = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end
endmodule
